// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle opcode sequencer stepping EXEC/MEM/WB.
// Drives latched control lines and a phase code; honours datapath stall.
module control_sequencer #(
  parameter int OPCODE_W   = 6,
  parameter int CTRL_W     = 6,
  parameter int MEM_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_valid,
  input  logic [OPCODE_W-1:0] io_opcode,
  output logic                io_ready,
  input  logic                io_stall,
  output logic [CTRL_W-1:0]   io_ctrl,
  output logic                io_ctrlValid,
  output logic [1:0]          io_phase,
  output logic                io_busy,
  output logic                io_done,
  output logic                io_illegal,
  output logic                io_halted
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MEM  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [3:0] MEM_LD = 4'(MEM_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                ill_q, ill_d;

  logic [1:0] cls_in;
  logic [1:0] cls_q;
  logic       accept;
  logic       is_alu, is_mem, is_multi, is_halt;
  logic       active;

  assign cls_in = io_opcode[OPCODE_W-1 -: 2];
  assign cls_q  = op_q[OPCODE_W-1 -: 2];
  assign active = ~reset;

  assign is_alu   = (cls_in == 2'b00);
  assign is_mem   = (cls_in == 2'b01);
  assign is_multi = (cls_in == 2'b10);
  assign is_halt  = &io_opcode;

  assign io_ready = active & (state_q == S_IDLE);
  assign accept   = io_valid & io_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = io_opcode;
          unique case (1'b1)
            is_alu, is_mem: begin
              state_d = S_EXEC;
              cnt_d   = 4'd0;
            end
            is_multi: begin
              state_d = S_EXEC;
              cnt_d   = {2'b00, io_opcode[1:0]};
            end
            is_halt: state_d = S_HALT;
            default: ill_d = 1'b1;
          endcase
        end
      end
      S_EXEC: begin
        if (!io_stall) begin
          if (cnt_q == 4'd0) begin
            if (cls_q == 2'b01) begin
              state_d = S_MEM;
              cnt_d   = MEM_LD;
            end else begin
              state_d = S_WB;
              cnt_d   = 4'd0;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_MEM: begin
        if (!io_stall) begin
          if (cnt_q == 4'd0) begin
            state_d = S_WB;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_WB: begin
        if (!io_stall) state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end

  logic [CTRL_W-1:0] ctrl_ext;

  if (CTRL_W <= OPCODE_W) begin : g_trunc
    assign ctrl_ext = op_q[CTRL_W-1:0];
  end else begin : g_zext
    assign ctrl_ext = {{(CTRL_W-OPCODE_W){1'b0}}, op_q};
  end

  // Outputs are gated by reset so an abandoned sequence shows nothing.
  logic [1:0] phase_raw;

  always_comb begin
    phase_raw = 2'd0;
    unique case (state_q)
      S_EXEC:  phase_raw = 2'd1;
      S_MEM:   phase_raw = 2'd2;
      S_WB:    phase_raw = 2'd3;
      default: phase_raw = 2'd0;
    endcase
  end

  assign io_busy = active & ((state_q == S_EXEC) |
                             (state_q == S_MEM)  |
                             (state_q == S_WB));
  assign io_phase     = active ? phase_raw : 2'd0;
  assign io_ctrlValid = io_busy & ~io_stall;
  assign io_ctrl      = io_ctrlValid ? ctrl_ext : '0;
  assign io_done      = active & (state_q == S_WB) & ~io_stall;
  assign io_illegal   = active & ill_q;
  assign io_halted    = active & (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench with a phase-list reference model.
// Directed scenarios followed by randomized opcodes, stalls and resets.
module tb_control_sequencer;

  localparam int MEM_CYCLES = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_valid = 1'b0;
  logic [5:0] io_opcode = 6'd0;
  logic       io_stall = 1'b0;
  logic       io_ready;
  logic [5:0] io_ctrl;
  logic       io_ctrlValid;
  logic [1:0] io_phase;
  logic       io_busy;
  logic       io_done;
  logic       io_illegal;
  logic       io_halted;

  control_sequencer #(
    .OPCODE_W(6),
    .CTRL_W(6),
    .MEM_CYCLES(MEM_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_valid(io_valid),
    .io_opcode(io_opcode),
    .io_ready(io_ready),
    .io_stall(io_stall),
    .io_ctrl(io_ctrl),
    .io_ctrlValid(io_ctrlValid),
    .io_phase(io_phase),
    .io_busy(io_busy),
    .io_done(io_done),
    .io_illegal(io_illegal),
    .io_halted(io_halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int ph;
    int ctrl;
  } ev_t;

  ev_t act_q[$];
  ev_t done_q[$];
  int  ill_q[$];

  int ph_q[$];
  bit m_halted = 1'b0;
  int cur_ctrl = 0;

  logic exp_ready = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_halted = 1'b0;
  logic exp_cv = 1'b0;
  int   exp_phase = 0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int last_done = -1;
  int last_ill = -1;
  int done_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got=unexpected want=none", nm, cyc);
  endtask

  // Model: an accepted opcode becomes a list of per-cycle phase codes.
  task automatic step(input bit v, input logic [5:0] op,
                      input bit st, input bit rs);
    ev_t e;
    if (rs) begin
      exp_ready  = 1'b0;
      exp_busy   = 1'b0;
      exp_phase  = 0;
      exp_halted = 1'b0;
      exp_cv     = 1'b0;
      if (ill_q.size() > 0 && ill_q[$] == cyc) void'(ill_q.pop_back());
      ph_q.delete();
      m_halted = 1'b0;
    end else begin
      exp_halted = m_halted;
      exp_busy   = ph_q.size() > 0;
      exp_phase  = exp_busy ? ph_q[0] : 0;
      exp_ready  = !exp_busy && !m_halted;
      exp_cv     = exp_busy && !st;
      if (exp_cv) begin
        e.cyc  = cyc;
        e.ph   = ph_q[0];
        e.ctrl = cur_ctrl;
        act_q.push_back(e);
        if (ph_q[0] == 3) done_q.push_back(e);
        void'(ph_q.pop_front());
      end
      if (exp_ready && v) begin
        cur_ctrl = int'(op);
        case (op[5:4])
          2'b00: ph_q = '{1, 3};
          2'b01: begin
            ph_q.push_back(1);
            repeat (MEM_CYCLES) ph_q.push_back(2);
            ph_q.push_back(3);
          end
          2'b10: begin
            repeat (int'(op[1:0]) + 1) ph_q.push_back(1);
            ph_q.push_back(3);
          end
          default: begin
            if (op == 6'h3f) m_halted = 1'b1;
            else ill_q.push_back(cyc + 1);
          end
        endcase
      end
    end
    reset     = rs;
    io_valid  = v;
    io_opcode = op;
    io_stall  = st;
    mon_en    = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  always @(negedge clock) begin
    ev_t e;
    if (mon_en) begin
      chk("ready", io_ready, exp_ready);
      chk("busy", io_busy, exp_busy);
      chk("halted", io_halted, exp_halted);
      chk("phase", io_phase, exp_phase);
      chk("ctrl_valid", io_ctrlValid, exp_cv);
      chk("done_ill_excl", io_done & io_illegal, 0);
      if (!io_ctrlValid) begin
        chk("ctrl_zero", io_ctrl, 0);
      end else if (act_q.size() == 0) begin
        miss("act_unexp");
      end else begin
        e = act_q.pop_front();
        chk("act_cyc", cyc, e.cyc);
        chk("act_phase", io_phase, e.ph);
        chk("act_ctrl", io_ctrl, e.ctrl);
      end
      if (io_done) begin
        done_cnt++;
        last_done = cyc;
        if (done_q.size() == 0) begin
          miss("done_unexp");
        end else begin
          e = done_q.pop_front();
          chk("done_cyc", cyc, e.cyc);
          chk("done_ctrl", io_ctrl, e.ctrl);
        end
      end
      if (io_illegal) begin
        last_ill = cyc;
        if (ill_q.size() == 0) miss("ill_unexp");
        else chk("ill_cyc", cyc, ill_q.pop_front());
      end
    end
  end

  initial begin
    int t;
    int d0;
    logic [5:0] op;
    @(posedge clock);
    #1;
    repeat (3) step(1'b0, 6'd0, 1'b0, 1'b1);
    idle(2);

    t = cyc;
    step(1'b1, 6'b000101, 1'b0, 1'b0);
    idle(4);
    chk("alu_lat", last_done - t, 2);

    t = cyc;
    step(1'b1, 6'b010011, 1'b0, 1'b0);
    idle(6);
    chk("mem_lat", last_done - t, 2 + MEM_CYCLES);

    t = cyc;
    step(1'b1, 6'b100011, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b1, 1'b0);
    idle(6);
    chk("multi_stall_lat", last_done - t, 6);

    t = cyc;
    step(1'b1, 6'b110000, 1'b0, 1'b0);
    step(1'b1, 6'b000001, 1'b0, 1'b0);
    idle(4);
    chk("ill_lat", last_ill - t, 1);
    chk("ill_then_alu_lat", last_done - t, 3);

    d0 = done_cnt;
    step(1'b1, 6'b010011, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 1'b1);
    idle(6);
    chk("rst_mid_nodone", done_cnt - d0, 0);
    t = cyc;
    step(1'b1, 6'b000010, 1'b0, 1'b0);
    idle(4);
    chk("after_rst_lat", last_done - t, 2);

    step(1'b1, 6'b111111, 1'b0, 1'b0);
    repeat (10) begin
      op = 6'($urandom);
      step(1'b1, op, 1'($urandom_range(0, 1)), 1'b0);
    end
    chk("halt_sticky", io_halted, 1);
    step(1'b0, 6'd0, 1'b0, 1'b1);
    idle(3);

    repeat (600) begin
      op = 6'($urandom);
      step(1'($urandom_range(0, 1)), op,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 39) == 0);
    end

    step(1'b0, 6'd0, 1'b0, 1'b1);
    idle(20);
    chk("act_q_left", act_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    chk("ill_q_left", ill_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
